// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: result-path defaults and branch-type encodings.
package alu_result_stage_pkg;

  localparam int DW_DEFAULT    = 32;
  localparam int DEPTH_DEFAULT = 2;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

endpackage

// File: rtl/alu_result_stage_branch_eval.sv
// Combinational branch decision from ALU flags and the branch kind.
module branch_eval
  import alu_result_stage_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       a_first,
  input  logic       a_zero,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(br_type))
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BLEZ: taken = a_first | a_zero;
      BR_BGTZ: taken = !a_first & !a_zero;
      BR_BLTZ: taken = a_first;
      BR_BGEZ: taken = !a_first;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result buffer: a small FIFO that stores each result together with its
// branch decision, which is resolved once at push time.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_c,
  input  logic                       in_zero,
  input  logic                       in_a_first,
  input  logic                       in_a_zero,
  input  logic [2:0]                 in_br_type,
  input  logic [4:0]                 in_rd,
  input  logic                       in_wen,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [4:0]                 out_rd,
  output logic                       out_wen,
  output logic                       out_br_taken,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = DW + 7;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW:0]   count_reg;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry;
  logic [EW-1:0] head;
  logic          br_taken;
  logic          push;
  logic          pop;

  branch_eval u_branch_eval (
    .br_type (in_br_type),
    .zero    (in_zero),
    .a_first (in_a_first),
    .a_zero  (in_a_zero),
    .taken   (br_taken)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_reg < FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign entry     = {br_taken, in_wen, in_rd, in_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: count_reg alone decides what is visible.
  // A write never targets the head slot while it is valid and not full,
  // so a stalled head stays stable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) mem[gi] <= entry;
    end
  end

  assign head = mem[rd_ptr_reg];

  assign out_data     = out_valid ? head[DW-1:0] : '0;
  assign out_rd       = out_valid ? head[DW+4:DW] : '0;
  assign out_wen      = out_valid ? head[DW+5] : 1'b0;
  assign out_br_taken = out_valid ? head[DW+6] : 1'b0;
  assign occupancy    = count_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of alu_result_stage against a queue model.
module tb_alu_result_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_c = '0;
  logic          in_zero = 1'b0;
  logic          in_a_first = 1'b0;
  logic          in_a_zero = 1'b0;
  logic [2:0]    in_br_type = 3'd0;
  logic [4:0]    in_rd = '0;
  logic          in_wen = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [4:0]    out_rd;
  logic          out_wen;
  logic          out_br_taken;
  logic [$clog2(DEPTH):0] occupancy;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    rd;
    logic          wen;
    logic          br;
  } ent_t;

  ent_t q[$];

  alu_result_stage #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_c         (in_c),
    .in_zero      (in_zero),
    .in_a_first   (in_a_first),
    .in_a_zero    (in_a_zero),
    .in_br_type   (in_br_type),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_wen      (out_wen),
    .out_br_taken (out_br_taken),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  // Branch rules read as comparisons of operand A against zero.
  function automatic logic exp_br(input logic [2:0] t, input logic z,
                                  input logic neg, input logic a_is_zero);
    logic le_zero;
    logic lt_zero;
    le_zero = neg || a_is_zero;
    lt_zero = neg;
    case (t)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return le_zero;
      3'd4:    return !le_zero;
      3'd5:    return lt_zero;
      3'd6:    return !lt_zero;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    h = '{data: '0, rd: '0, wen: 1'b0, br: 1'b0};
    if (q.size() > 0) h = q[0];
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("out_data", 64'(out_data), 64'(h.data));
    chk("out_rd", 64'(out_rd), 64'(h.rd));
    chk("out_wen", 64'(out_wen), 64'(h.wen));
    chk("out_br_taken", 64'(out_br_taken), 64'(h.br));
  endtask

  // Check current outputs, clock once, then advance the model.
  task automatic cycle();
    bit   push;
    bit   pop;
    ent_t e;
    check_outputs();
    push = in_valid && (q.size() < DEPTH) && !flush;
    pop  = (q.size() > 0) && out_ready && !flush;
    e = '{data: in_c, rd: in_rd, wen: in_wen,
          br: exp_br(in_br_type, in_zero, in_a_first, in_a_zero)};
    @(posedge clk);
    #1;
    if (flush) begin
      if (q.size() > 0) $display("flush drops %0d entries", q.size());
      q.delete();
    end else begin
      if (pop) begin
        $display("pop  data=%08h rd=%0d wen=%0b br=%0b", q[0].data, q[0].rd, q[0].wen, q[0].br);
        void'(q.pop_front());
      end
      if (push) q.push_back(e);
    end
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] c, input logic [4:0] rd,
                        input logic wen, input logic [2:0] t);
    in_valid   = v;
    in_c       = c;
    in_rd      = rd;
    in_wen     = wen;
    in_br_type = t;
    in_zero    = 1'b0;
    in_a_first = 1'b0;
    in_a_zero  = 1'b0;
  endtask

  initial begin
    logic [2:0] flags;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cycle();

    // Single push with immediate visibility
    out_ready = 1'b1;
    set_in(1'b1, 32'h0000_0005, 5'd3, 1'b1, 3'd0);
    cycle();
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'h5);
    chk("single_rd", 64'(out_rd), 64'd3);
    chk("single_br", 64'(out_br_taken), 64'd0);
    cycle();

    // Branch table sweep, one push per cycle while draining
    for (int t = 0; t < 8; t++) begin
      for (int f = 0; f < 8; f++) begin
        flags = 3'(f);
        set_in(1'b1, DW'($urandom), 5'($urandom), 1'($urandom), 3'(t));
        in_zero    = flags[2];
        in_a_first = flags[1];
        in_a_zero  = flags[0];
        cycle();
      end
    end
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    cycle();
    cycle();

    // Back-pressure: fill, attempt a third push, then drain
    out_ready = 1'b0;
    set_in(1'b1, 32'hA, 5'd1, 1'b1, 3'd0);
    cycle();
    set_in(1'b1, 32'hB, 5'd2, 1'b1, 3'd0);
    cycle();
    set_in(1'b1, 32'hC, 5'd3, 1'b1, 3'd0);
    cycle();
    chk("bp_full_occ", 64'(occupancy), 64'd2);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    out_ready = 1'b1;
    chk("bp_first", 64'(out_data), 64'hA);
    cycle();
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    chk("bp_second", 64'(out_data), 64'hB);
    cycle();
    cycle();

    // Streaming at occupancy 1
    out_ready = 1'b0;
    set_in(1'b1, 32'h100, 5'd7, 1'b1, 3'd0);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, DW'(32'h200 + i), 5'(i), 1'b1, 3'd0);
      cycle();
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    cycle();

    // Flush with a simultaneous push at occupancy 2
    out_ready = 1'b0;
    set_in(1'b1, 32'h11, 5'd1, 1'b0, 3'd1);
    cycle();
    set_in(1'b1, 32'h22, 5'd2, 1'b1, 3'd2);
    cycle();
    set_in(1'b1, 32'h33, 5'd3, 1'b1, 3'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cycle();

    // Asynchronous reset mid-cycle at occupancy 2
    out_ready = 1'b0;
    set_in(1'b1, 32'h44, 5'd4, 1'b1, 3'd0);
    cycle();
    set_in(1'b1, 32'h55, 5'd5, 1'b1, 3'd0);
    cycle();
    set_in(1'b1, 32'h66, 5'd6, 1'b1, 3'd0);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    check_outputs();
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b1, 32'h77, 5'd9, 1'b1, 3'd4);
    cycle();
    set_in(1'b1, 32'h88, 5'd10, 1'b0, 3'd0);
    out_ready = 1'b1;
    chk("arst_first_out", 64'(out_data), 64'h77);
    cycle();
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    cycle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), DW'($urandom), 5'($urandom), 1'($urandom), 3'($urandom));
      in_zero    = 1'($urandom);
      in_a_first = 1'($urandom);
      in_a_zero  = 1'($urandom);
      out_ready  = 1'($urandom);
      flush      = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 3'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DW, default 32, data width of the ALU result path.
REQ-002 Parameter DEPTH, default 2, buffer entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  ALU result presented this cycle.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_c  input  DW  ALU result C.
REQ-009 in_zero  input  1  ALU Zero flag.
REQ-010 in_a_first  input  1  sign bit of ALU operand A.
REQ-011 in_a_zero  input  1  ALU operand A equals zero.
REQ-012 in_br_type  input  3  branch kind: 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved.
REQ-013 in_rd  input  5  destination register index.
REQ-014 in_wen  input  1  register write enable.
REQ-015 out_valid  output  1  head entry valid.
REQ-016 out_ready  input  1  consumer accepts head entry.
REQ-017 out_data  output  DW  buffered ALU result.
REQ-018 out_rd  output  5  buffered destination index.
REQ-019 out_wen  output  1  buffered write enable.
REQ-020 out_br_taken  output  1  branch decision of head entry.
REQ-021 occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-022 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
REQ-023 in_ready SHALL equal (occupancy < DEPTH), driven from registered state only; it SHALL have no combinational path from out_ready.
REQ-024 The branch decision SHALL be evaluated at push and stored: BEQ=in_zero, BNE=!in_zero, BLEZ=in_a_first|in_a_zero, BGTZ=!in_a_first&!in_a_zero, BLTZ=in_a_first, BGEZ=!in_a_first; types 0 and 7 give 0.
REQ-025 Latency: an entry pushed in cycle N SHALL appear on out_* with out_valid high in cycle N+1 when the buffer was empty.
REQ-026 Entries SHALL leave in push order (FIFO); read and write pointers wrap modulo DEPTH.
REQ-027 While out_valid is high and out_ready is low, all out_* SHALL hold stable.
REQ-028 Simultaneous push and pop SHALL leave occupancy unchanged; at full, no push occurs, so occupancy decrements on pop.
REQ-029 When out_valid is low, out_data, out_rd, out_wen and out_br_taken SHALL be 0.
REQ-030 flush SHALL set occupancy to 0 and out_valid to 0 at the next edge; it overrides push and pop in the same cycle.
REQ-031 Types 0 and 7 SHALL still be buffered and passed with out_wen unchanged.

Reset
REQ-032 rst_n low SHALL immediately clear pointers, occupancy, out_valid and all out_* to 0, and set in_ready to 1.
REQ-033 An entry mid-handshake at reset assertion SHALL be discarded; after rst_n rises, the first push is the first entry out.

Structure
REQ-034 Branch-type encodings and DEPTH/DW defaults SHALL live in the shared ALU definitions package.
REQ-035 Branch evaluation SHALL be one combinational sub-module, branch_eval, instantiated once at the input.

Verification
REQ-036 Single push: in_c=0x0000_0005, rd=3, wen=1, type 0, out_ready=1 -> next cycle out_valid=1, out_data=5, out_rd=3, out_br_taken=0.
REQ-037 Branch table: for each type 1-6, sweep (zero, a_first, a_zero) over the 8 flag combinations -> out_br_taken matches REQ-024; type 7 gives 0.
REQ-038 Back-pressure: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0, third push ignored; release out_ready -> 0xA then 0xB, in_ready=1 after the first pop.
REQ-039 Streaming: continuous push and pop for 16 cycles, occupancy 1 -> occupancy stays 1, data in order, no bubbles.
REQ-040 Flush with simultaneous push at occupancy 2 -> next cycle occupancy=0, out_valid=0, pushed entry lost.
REQ-041 Assert rst_n=0 asynchronously mid-cycle with occupancy 2 -> outputs are 0 before the next clock edge; after release, first push exits first.
